jtag_tap_ctrl: RTL and testbench

//  IEEE 1149.1 TAP controller that sequences the JTAG datapath and drives the TDO output buffer.
//  - Runs the 16-state TAP FSM from TMS.
//  - Holds the instruction register and decodes it into data-register selects.
//  - Owns the 1-bit BYPASS register and the 32-bit IDCODE register.
//  - Produces EN_TDO and the serial bit (OUT_TRIG) that feeds the tri-state TDO buffer stage.
//  - The external boundary-scan chain attaches through DR_TDO and the capture/shift/update strobes.

---
 rtl/jtag_pkg.sv | 61 ++++++
 rtl/jtag_tap_ctrl_if.sv | 26 ++
 rtl/jtag_tap_fsm.sv | 26 ++
 rtl/jtag_tap_ctrl.sv | 134 +++++++++++++
 tb/tb_jtag_tap_ctrl.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/jtag_pkg.sv
// Shared TAP state encodings, default opcodes and the 1149.1 next-state function.
package jtag_pkg;

  typedef enum logic [3:0] {
    TLR    = 4'hF,
    RTI    = 4'hC,
    SEL_DR = 4'h7,
    CAP_DR = 4'h6,
    SH_DR  = 4'h2,
    EX1_DR = 4'h1,
    PA_DR  = 4'h3,
    EX2_DR = 4'h0,
    UPD_DR = 4'h5,
    SEL_IR = 4'h4,
    CAP_IR = 4'hE,
    SH_IR  = 4'hA,
    EX1_IR = 4'h9,
    PA_IR  = 4'hB,
    EX2_IR = 4'h8,
    UPD_IR = 4'hD
  } tap_state_e;

  // Which data register sits between TDI and TDO
  typedef enum logic [1:0] {
    DR_BYPASS = 2'd0,
    DR_IDCODE = 2'd1,
    DR_BSCAN  = 2'd2
  } dr_sel_e;

  localparam int unsigned IR_WIDTH_DEF   = 4;
  localparam logic [31:0] IDCODE_DEF     = 32'h1000_0001;
  localparam logic [3:0]  OP_IDCODE_DEF  = 4'b0001;
  localparam logic [3:0]  OP_EXTEST_DEF  = 4'b0000;
  localparam logic [3:0]  OP_SAMPLE_DEF  = 4'b0010;

  // Standard TAP transition graph, steered by TMS
  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_state_e n;
    case (s)
      TLR:     n = tms ? TLR    : RTI;
      RTI:     n = tms ? SEL_DR : RTI;
      SEL_DR:  n = tms ? SEL_IR : CAP_DR;
      CAP_DR:  n = tms ? EX1_DR : SH_DR;
      SH_DR:   n = tms ? EX1_DR : SH_DR;
      EX1_DR:  n = tms ? UPD_DR : PA_DR;
      PA_DR:   n = tms ? EX2_DR : PA_DR;
      EX2_DR:  n = tms ? UPD_DR : SH_DR;
      UPD_DR:  n = tms ? SEL_DR : RTI;
      SEL_IR:  n = tms ? TLR    : CAP_IR;
      CAP_IR:  n = tms ? EX1_IR : SH_IR;
      SH_IR:   n = tms ? EX1_IR : SH_IR;
      EX1_IR:  n = tms ? UPD_IR : PA_IR;
      PA_IR:   n = tms ? EX2_IR : PA_IR;
      EX2_IR:  n = tms ? UPD_IR : SH_IR;
      UPD_IR:  n = tms ? SEL_DR : RTI;
      default: n = TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_tap_ctrl_if.sv
// JTAG pin-side and boundary-scan-side signal bundle of the TAP controller.
interface jtag_tap_ctrl_if #(
  parameter int unsigned IR_WIDTH = 4
);
  logic                tms;
  logic                tdi;
  logic                dr_tdo;
  logic                out_trig;
  logic                en_tdo;
  logic                capture_dr;
  logic                shift_dr;
  logic                update_dr;
  logic                extest_sel;
  logic [IR_WIDTH-1:0] ir_out;
  logic [3:0]          tap_state;

  modport master (
    output tms, tdi, dr_tdo,
    input  out_trig, en_tdo, capture_dr, shift_dr, update_dr, extest_sel, ir_out, tap_state
  );

  modport slave (
    input  tms, tdi, dr_tdo,
    output out_trig, en_tdo, capture_dr, shift_dr, update_dr, extest_sel, ir_out, tap_state
  );
endinterface

// File: rtl/jtag_tap_fsm.sv
// TAP state register; exposes both the current and the upcoming state.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck_i,
  input  logic       trst_n_i,
  input  logic       tms_i,
  output tap_state_e state_o,
  output tap_state_e next_state_o
);

  tap_state_e state_q;

  assign next_state_o = tap_next(state_q, tms_i);
  assign state_o      = state_q;

  // Advance the TAP state on every TCK rise; TRST low parks it in Test-Logic-Reset
  always_ff @(posedge tck_i) begin
    if (!trst_n_i) begin
      state_q <= TLR;
    end else begin
      state_q <= next_state_o;
    end
  end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller: IR, BYPASS/IDCODE registers, DR strobes and TDO buffer drive.
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter int unsigned         IR_WIDTH   = IR_WIDTH_DEF,
  parameter logic [31:0]         IDCODE_VAL = IDCODE_DEF,
  parameter logic [IR_WIDTH-1:0] OP_BYPASS  = {IR_WIDTH{1'b1}},
  parameter logic [IR_WIDTH-1:0] OP_IDCODE  = IR_WIDTH'(OP_IDCODE_DEF),
  parameter logic [IR_WIDTH-1:0] OP_EXTEST  = IR_WIDTH'(OP_EXTEST_DEF),
  parameter logic [IR_WIDTH-1:0] OP_SAMPLE  = IR_WIDTH'(OP_SAMPLE_DEF)
) (
  input  logic          tck_i,
  input  logic          trst_n_i,
  jtag_tap_ctrl_if.slave bus
);

  tap_state_e          state_s;
  tap_state_e          next_state_s;
  dr_sel_e             dr_sel_s;
  logic                bscan_s;

  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
  logic                bypass_q, bypass_d;
  logic [31:0]         idcode_sr_q, idcode_sr_d;
  logic                en_tdo_q, en_tdo_d;
  logic                out_trig_s;

  jtag_tap_fsm u_fsm (
    .tck_i        (tck_i),
    .trst_n_i     (trst_n_i),
    .tms_i        (bus.tms),
    .state_o      (state_s),
    .next_state_o (next_state_s)
  );

  // Decode the active instruction; unknown opcodes fall back to BYPASS
  always_comb begin
    dr_sel_s = DR_BYPASS;
    if (ir_q == OP_BYPASS) begin
      dr_sel_s = DR_BYPASS;
    end else if (ir_q == OP_IDCODE) begin
      dr_sel_s = DR_IDCODE;
    end else if ((ir_q == OP_EXTEST) || (ir_q == OP_SAMPLE)) begin
      dr_sel_s = DR_BSCAN;
    end else begin
      dr_sel_s = DR_BYPASS;
    end
  end

  assign bscan_s = (dr_sel_s == DR_BSCAN);

  // Next values of IR, IR shifter and internal DRs for the current TAP state
  always_comb begin
    ir_d        = ir_q;
    ir_sr_d     = ir_sr_q;
    bypass_d    = bypass_q;
    idcode_sr_d = idcode_sr_q;
    case (state_s)
      CAP_IR: ir_sr_d = IR_WIDTH'(2'b01);
      SH_IR:  ir_sr_d = {bus.tdi, ir_sr_q[IR_WIDTH-1:1]};
      UPD_IR: ir_d    = ir_sr_q;
      CAP_DR: begin
        if (dr_sel_s == DR_IDCODE) begin
          idcode_sr_d = IDCODE_VAL;
        end else if (dr_sel_s == DR_BYPASS) begin
          bypass_d = 1'b0;
        end else begin
          bypass_d = bypass_q;
        end
      end
      SH_DR: begin
        if (dr_sel_s == DR_IDCODE) begin
          idcode_sr_d = {bus.tdi, idcode_sr_q[31:1]};
        end else if (dr_sel_s == DR_BYPASS) begin
          bypass_d = bus.tdi;
        end else begin
          bypass_d = bypass_q;
        end
      end
      default: ir_d = ir_q;
    endcase
    // Walking into Test-Logic-Reset via TMS restores the IDCODE instruction
    if (next_state_s == TLR) begin
      ir_d = OP_IDCODE;
    end else begin
      ir_d = ir_d;
    end
    en_tdo_d = (next_state_s == SH_IR) || (next_state_s == SH_DR);
  end

  // Register the datapath; TRST low discards any partial shift
  always_ff @(posedge tck_i) begin
    if (!trst_n_i) begin
      ir_q        <= OP_IDCODE;
      ir_sr_q     <= '0;
      bypass_q    <= 1'b0;
      idcode_sr_q <= 32'h0000_0000;
      en_tdo_q    <= 1'b0;
    end else begin
      ir_q        <= ir_d;
      ir_sr_q     <= ir_sr_d;
      bypass_q    <= bypass_d;
      idcode_sr_q <= idcode_sr_d;
      en_tdo_q    <= en_tdo_d;
    end
  end

  // Serial bit toward the TDO buffer, taken from whichever register is in the scan path
  always_comb begin
    out_trig_s = 1'b0;
    if (state_s == SH_IR) begin
      out_trig_s = ir_sr_q[0];
    end else if (state_s == SH_DR) begin
      case (dr_sel_s)
        DR_IDCODE: out_trig_s = idcode_sr_q[0];
        DR_BSCAN:  out_trig_s = bus.dr_tdo;
        default:   out_trig_s = bypass_q;
      endcase
    end else begin
      out_trig_s = 1'b0;
    end
  end

  assign bus.out_trig   = out_trig_s;
  assign bus.en_tdo     = en_tdo_q;
  assign bus.capture_dr = bscan_s && (state_s == CAP_DR);
  assign bus.shift_dr   = bscan_s && (state_s == SH_DR);
  assign bus.update_dr  = bscan_s && (state_s == UPD_DR);
  assign bus.extest_sel = (ir_q == OP_EXTEST);
  assign bus.ir_out     = ir_q;
  assign bus.tap_state  = state_s;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl with a table-driven reference model checked every cycle.
module tb_jtag_tap_ctrl;

  logic tck = 1'b0;
  logic trst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  jtag_tap_ctrl_if #(.IR_WIDTH(4)) bus ();

  jtag_tap_ctrl u_dut (
    .tck_i    (tck),
    .trst_n_i (trst_n),
    .bus      (bus)
  );

  always #5 tck = ~tck;

  // ---------------- reference model ----------------
  logic [3:0]  nx0 [16];
  logic [3:0]  nx1 [16];
  logic [3:0]  m_state;
  logic [3:0]  m_ir;
  logic [3:0]  m_irsr;
  logic        m_byp;
  logic [31:0] m_id;
  logic        m_en;
  logic        m_ok = 1'b0;

  initial begin
    // transition table: {state, next on TMS=0, next on TMS=1}
    nx0[4'hF] = 4'hC; nx1[4'hF] = 4'hF;
    nx0[4'hC] = 4'hC; nx1[4'hC] = 4'h7;
    nx0[4'h7] = 4'h6; nx1[4'h7] = 4'h4;
    nx0[4'h6] = 4'h2; nx1[4'h6] = 4'h1;
    nx0[4'h2] = 4'h2; nx1[4'h2] = 4'h1;
    nx0[4'h1] = 4'h3; nx1[4'h1] = 4'h5;
    nx0[4'h3] = 4'h3; nx1[4'h3] = 4'h0;
    nx0[4'h0] = 4'h2; nx1[4'h0] = 4'h5;
    nx0[4'h5] = 4'hC; nx1[4'h5] = 4'h7;
    nx0[4'h4] = 4'hE; nx1[4'h4] = 4'hF;
    nx0[4'hE] = 4'hA; nx1[4'hE] = 4'h9;
    nx0[4'hA] = 4'hA; nx1[4'hA] = 4'h9;
    nx0[4'h9] = 4'hB; nx1[4'h9] = 4'hD;
    nx0[4'hB] = 4'hB; nx1[4'hB] = 4'h8;
    nx0[4'h8] = 4'hA; nx1[4'h8] = 4'hD;
    nx0[4'hD] = 4'hC; nx1[4'hD] = 4'h7;
  end

  always @(posedge tck) begin
    logic [3:0] nxt;
    if (!trst_n) begin
      m_state = 4'hF; m_ir = 4'h1; m_irsr = 4'h0; m_byp = 1'b0; m_id = 32'h0; m_en = 1'b0;
      m_ok = 1'b1;
    end else if (m_ok) begin
      nxt = bus.tms ? nx1[m_state] : nx0[m_state];
      if (m_state == 4'hE) m_irsr = 4'h1;
      else if (m_state == 4'hA) m_irsr = (m_irsr >> 1) | (bus.tdi ? 4'h8 : 4'h0);
      else if (m_state == 4'hD) m_ir = m_irsr;
      else if (m_state == 4'h6) begin
        m_byp = 1'b0;
        if (m_ir == 4'h1) m_id = 32'h1000_0001;
      end else if (m_state == 4'h2) begin
        m_byp = bus.tdi;
        if (m_ir == 4'h1) m_id = (m_id >> 1) | (bus.tdi ? 32'h8000_0000 : 32'h0);
      end
      m_en = (nxt == 4'hA) || (nxt == 4'h2);
      if (nxt == 4'hF) m_ir = 4'h1;
      m_state = nxt;
    end
  end

  // Compare every DUT output against the model mid-cycle
  always @(negedge tck) begin
    logic bs, ot;
    logic [13:0] exp_v, act_v;
    if (m_ok) begin
      bs = (m_ir == 4'h0) || (m_ir == 4'h2);
      if (m_state == 4'hA) ot = m_irsr[0];
      else if (m_state == 4'h2) ot = bs ? bus.dr_tdo : ((m_ir == 4'h1) ? m_id[0] : m_byp);
      else ot = 1'b0;
      exp_v = {m_state, m_ir, m_en, ot, bs && (m_state == 4'h6), bs && (m_state == 4'h2),
               bs && (m_state == 4'h5), m_ir == 4'h0};
      act_v = {bus.tap_state, bus.ir_out, bus.en_tdo, bus.out_trig, bus.capture_dr,
               bus.shift_dr, bus.update_dr, bus.extest_sel};
      n_tests++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL cycle t=%0t {st,ir,en,ot,cap,sh,upd,ext} got %b want %b", $time, act_v, exp_v);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input logic t, input logic d);
    bus.tms = t;
    bus.tdi = d;
    @(posedge tck);
    #2;
  endtask

  initial begin
    logic [31:0] cap;
    int          en_cnt;

    trst_n = 1'b0; bus.tms = 1'b0; bus.tdi = 1'b0; bus.dr_tdo = 1'b0;
    step(1'b0, 1'b0);
    trst_n = 1'b1;

    // 1. reset then TMS=0 -> RTI
    step(1'b0, 1'b0);
    check("rst_state", 32'(bus.tap_state), 32'hC);
    check("rst_ir", 32'(bus.ir_out), 32'h1);
    check("rst_en", 32'(bus.en_tdo), 32'h0);

    // 2. five TMS=1 from RTI, Shift-DR and Pause-IR
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check("tlr_from_rti", 32'(bus.tap_state), 32'hF);
    step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    check("at_sh_dr", 32'(bus.tap_state), 32'h2);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check("tlr_from_shdr", 32'(bus.tap_state), 32'hF);
    step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
    step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
    check("at_pa_ir", 32'(bus.tap_state), 32'hB);
    check("pa_ir_en", 32'(bus.en_tdo), 32'h0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check("tlr_from_pair", 32'(bus.tap_state), 32'hF);

    // 3. IDCODE scan
    step(1'b0, 1'b0);
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    cap = 32'h0; en_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      cap[i] = bus.out_trig;
      en_cnt += int'(bus.en_tdo);
      step(i == 31, 1'b0);
    end
    en_cnt += int'(bus.en_tdo);
    check("idcode_stream", cap, 32'h1000_0001);
    check("idcode_en_cycles", 32'(en_cnt), 32'd32);
    step(1'b1, 1'b0); step(1'b0, 1'b0);

    // 4. load BYPASS (1111) then 1-bit delay DR scan
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    cap = 32'h0;
    for (int i = 0; i < 4; i++) begin
      cap[i] = bus.out_trig;
      step(i == 3, 1'b1);
    end
    check("ir_capture_bits", cap, 32'h1);
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    check("ir_bypass", 32'(bus.ir_out), 32'hF);
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    cap = 32'h0;
    for (int i = 0; i < 3; i++) begin
      cap[i] = bus.out_trig;
      step(i == 2, (i != 1));
    end
    check("bypass_delay", cap, 32'h2);
    step(1'b1, 1'b0); step(1'b0, 1'b0);

    // 5. EXTEST: strobes and DR_TDO pass-through
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(i == 3, 1'b0);
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    check("extest_sel", 32'(bus.extest_sel), 32'h1);
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    check("capture_dr", 32'(bus.capture_dr), 32'h1);
    step(1'b0, 1'b0);
    check("shift_dr", 32'(bus.shift_dr), 32'h1);
    bus.dr_tdo = 1'b1; #1;
    check("dr_tdo_hi", 32'(bus.out_trig), 32'h1);
    bus.dr_tdo = 1'b0; #1;
    check("dr_tdo_lo", 32'(bus.out_trig), 32'h0);
    step(1'b1, 1'b0); step(1'b1, 1'b0);
    check("update_dr", 32'(bus.update_dr), 32'h1);
    step(1'b0, 1'b0);

    // 6. TRST during 3rd bit of an IR shift
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    step(1'b0, 1'b0); step(1'b0, 1'b1);
    trst_n = 1'b0;
    step(1'b0, 1'b0);
    trst_n = 1'b1;
    check("abort_state", 32'(bus.tap_state), 32'hF);
    check("abort_ir", 32'(bus.ir_out), 32'h1);
    check("abort_en", 32'(bus.en_tdo), 32'h0);
    step(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
